// File: rtl/rtc_bus_ctrl.sv
//============================================================================
// Module      : rtc_bus_ctrl
// Description : Multiplexed address/data bus master for an RTC chip. A
//               single transaction is an address phase (A_SET, A_STB,
//               A_HOLD) followed by a data phase (D_SET, D_STB, D_HOLD),
//               each state lasting T_PHASE clocks, then a one-cycle FIN
//               that pulses done. The bidirectional A_D bus is split into
//               ad_out / ad_oe / ad_in; the tri-state pad lives above.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   T_PHASE  clock cycles per bus state (1..255)
// Ports
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   start    transaction request, sampled only in IDLE
//   rw       1 = read, 0 = write (latched with start)
//   addr     RTC register address (latched with start)
//   wdata    write data (latched with start)
//   rdata    last read data, held until the next read completes
//   busy     high while a transaction is in flight (incl. FIN)
//   done     one-cycle completion pulse
//   err      write-verify mismatch, valid with done
//   CS/RD/WR active-low strobes
//   AD       low = address phase, high = data phase
//   ad_out   bus output value, ad_oe its output enable
//   ad_in    bus input value
// Build option
//   RTC_BUS_WRITE_VERIFY_EN : every write is followed by an automatic
//   read-back of the same address; err flags a read-back mismatch.
//============================================================================
`default_nettype none

module rtc_bus_ctrl #(
    parameter int T_PHASE = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       AD,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [7:0] C_LAST = 8'(T_PHASE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_SET  = 3'd1,
        A_STB  = 3'd2,
        A_HOLD = 3'd3,
        D_SET  = 3'd4,
        D_STB  = 3'd5,
        D_HOLD = 3'd6,
        FIN    = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    logic       w_last;
    logic       r_rw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       w_read;
    logic       w_verify_next;

    // Last cycle of a timed state; the counter restarts on every state entry.
    assign w_last = (r_cnt == C_LAST);

`ifdef RTC_BUS_WRITE_VERIFY_EN
    logic r_verify;   // current pass is the automatic read-back of a write
    logic r_err;

    assign w_read        = r_rw | r_verify;
    assign w_verify_next = ~r_rw & ~r_verify;
    assign err           = r_err;
`else
    assign w_read        = r_rw;
    assign w_verify_next = 1'b0;
    assign err           = 1'b0;
`endif

    assign rdata = r_rdata;

    //------------------------------------------------------------------------
    // State register, phase counter and operand latches
    //------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_rw    <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
            r_rdata <= 8'd0;
        end else begin
            r_state <= w_next_state;

            if (r_state == IDLE || w_next_state != r_state)
                r_cnt <= 8'd0;
            else
                r_cnt <= r_cnt + 8'd1;

            if (r_state == IDLE && start) begin
                r_rw    <= rw;
                r_addr  <= addr;
                r_wdata <= wdata;
            end

            // Sample the RTC output just before RD is released.
            if (r_state == D_STB && w_last && w_read)
                r_rdata <= ad_in;
        end
    end

`ifdef RTC_BUS_WRITE_VERIFY_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_verify <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_verify <= 1'b0;
                r_err    <= 1'b0;
            end else if (r_state == D_HOLD && w_last) begin
                if (w_verify_next)
                    r_verify <= 1'b1;
                // r_rdata already holds the read-back captured in D_STB.
                if (r_verify)
                    r_err <= (r_rdata != r_wdata);
            end
        end
    end
`endif

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = A_SET;
            A_SET:   if (w_last) w_next_state = A_STB;
            A_STB:   if (w_last) w_next_state = A_HOLD;
            A_HOLD:  if (w_last) w_next_state = D_SET;
            D_SET:   if (w_last) w_next_state = D_STB;
            D_STB:   if (w_last) w_next_state = D_HOLD;
            D_HOLD:  if (w_last) w_next_state = w_verify_next ? A_SET : FIN;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    //------------------------------------------------------------------------
    // Bus outputs, decoded from state only so that a reset edge releases
    // every strobe on that same edge.
    //------------------------------------------------------------------------
    always_comb begin
        CS     = 1'b1;
        RD     = 1'b1;
        WR     = 1'b1;
        AD     = 1'b1;
        ad_oe  = 1'b0;
        ad_out = 8'd0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: busy = 1'b0;
            A_SET, A_HOLD: begin
                CS     = 1'b0;
                AD     = 1'b0;
                ad_oe  = 1'b1;
                ad_out = r_addr;
            end
            A_STB: begin
                CS     = 1'b0;
                AD     = 1'b0;
                ad_oe  = 1'b1;
                ad_out = r_addr;
                WR     = 1'b0;
            end
            D_SET, D_HOLD: begin
                CS = 1'b0;
                if (!w_read) begin
                    ad_oe  = 1'b1;
                    ad_out = r_wdata;
                end
            end
            D_STB: begin
                CS = 1'b0;
                if (w_read) begin
                    RD = 1'b0;
                end else begin
                    ad_oe  = 1'b1;
                    ad_out = r_wdata;
                    WR     = 1'b0;
                end
            end
            FIN:     done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
//============================================================================
// Module      : tb_rtc_bus_ctrl
// Description : Directed self-checking bench for rtc_bus_ctrl. Two
//               instances share bus inputs: dut0 with T_PHASE=10 and dut1
//               with T_PHASE=1, each with its own start. Expected bus
//               state per cycle comes from a cycle-position model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_rtc_bus_ctrl;

`ifdef RTC_BUS_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    // {CS,RD,WR,AD,ad_oe,busy,done} = 1111000, ad_out = 0
    localparam logic [14:0] C_IDLE_BUS = 15'h7800;

    logic       CLK;
    logic       RST;
    logic       start0, start1;
    logic       rw;
    logic [7:0] addr, wdata, ad_in;

    logic [7:0] rdata0, ad_out0, rdata1, ad_out1;
    logic       busy0, done0, err0, CS0, RD0, WR0, AD0, ad_oe0;
    logic       busy1, done1, err1, CS1, RD1, WR1, AD1, ad_oe1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_rd [2];

    rtc_bus_ctrl #(.T_PHASE(10)) dut0 (
        .CLK(CLK), .RST(RST), .start(start0), .rw(rw), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .busy(busy0), .done(done0),
        .err(err0), .CS(CS0), .RD(RD0), .WR(WR0), .AD(AD0),
        .ad_out(ad_out0), .ad_oe(ad_oe0), .ad_in(ad_in)
    );

    rtc_bus_ctrl #(.T_PHASE(1)) dut1 (
        .CLK(CLK), .RST(RST), .start(start1), .rw(rw), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .busy(busy1), .done(done1),
        .err(err1), .CS(CS1), .RD(RD1), .WR(WR1), .AD(AD1),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] obs_bus(input int which);
        if (which == 1)
            return {CS1, RD1, WR1, AD1, ad_oe1, busy1, done1, ad_out1};
        return {CS0, RD0, WR0, AD0, ad_oe0, busy0, done0, ad_out0};
    endfunction

    // Expected bus for cycle n after the accepting edge (n=1 is first A_SET).
    function automatic logic [14:0] exp_bus(input int n, input int t, input logic rw_i,
                                            input logic [7:0] a, input logic [7:0] wd,
                                            input int total);
        logic cs, rd, wr, ad, oe, bsy, dn, r;
        logic [7:0] d;
        int p, m, ph;
        cs = 1; rd = 1; wr = 1; ad = 1; oe = 0; bsy = 0; dn = 0; d = 8'h00;
        if (n == total) begin
            bsy = 1; dn = 1;
        end else if (n < total) begin
            p  = (n - 1) / (6 * t);
            m  = (n - 1) % (6 * t);
            ph = m / t;
            r  = rw_i | (p != 0);
            bsy = 1; cs = 0;
            if (ph < 3) begin
                ad = 0; oe = 1; d = a; wr = (ph != 1);
            end else if (r) begin
                rd = (ph != 4);
            end else begin
                oe = 1; d = wd; wr = (ph != 4);
            end
        end
        return {cs, rd, wr, ad, oe, bsy, dn, d};
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 1) start1 = v;
        else            start0 = v;
    endtask

    // One transaction; rb is what the RTC returns on ad_in at read capture.
    // poke>0 pulses start (with scrambled operands) at that cycle.
    task automatic run_txn(input string name, input int which, input int t,
                           input logic rw_i, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] rb, input int poke);
        int         total, dones;
        logic [7:0] new_rd;
        logic       exp_err;
        total   = (VERIFY && !rw_i) ? 12 * t + 1 : 6 * t + 1;
        new_rd  = (rw_i || VERIFY) ? rb : exp_rd[which];
        exp_err = VERIFY && !rw_i && (rb != wd);
        dones   = 0;
        rw = rw_i; addr = a; wdata = wd; ad_in = 8'h5A;
        set_start(which, 1'b1);
        for (int n = 1; n <= total + 1; n++) begin
            @(posedge CLK);
            #1;
            if (n == 1) set_start(which, 1'b0);
            if (poke > 0 && n == poke) begin
                set_start(which, 1'b1);
                rw = ~rw_i; addr = ~a; wdata = ~wd;
            end
            if (poke > 0 && n == poke + 1) set_start(which, 1'b0);
            check($sformatf("%s_bus_c%0d", name, n), obs_bus(which),
                  exp_bus(n, t, rw_i, a, wd, total));
            if (obs_bus(which) & 15'h0100) dones++;
            if (n == 5 * t)
                check($sformatf("%s_rdata_hold", name),
                      (which == 1) ? rdata1 : rdata0, exp_rd[which]);
            if (n == total) begin
                check($sformatf("%s_rdata", name), (which == 1) ? rdata1 : rdata0, new_rd);
                check($sformatf("%s_err", name), (which == 1) ? err1 : err0, exp_err);
            end
            if ((rw_i && n == 5 * t) || (VERIFY && !rw_i && n == 11 * t))
                ad_in = rb;
            else
                ad_in = 8'h5A;
        end
        check($sformatf("%s_done_count", name), dones, 1);
        exp_rd[which] = new_rd;
    endtask

    initial begin
        int dn, bz;
        RST = 1'b1; start0 = 1'b0; start1 = 1'b0;
        rw = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_bus0", obs_bus(0), C_IDLE_BUS);
        check("rst_bus1", obs_bus(1), C_IDLE_BUS);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_err0", err0, 1'b0);
        RST = 1'b0;

        // T_PHASE=10 transactions
        run_txn("wr21", 0, 10, 1'b0, 8'h21, 8'h45, 8'h45, 0);
        run_txn("rd22", 0, 10, 1'b1, 8'h22, 8'h00, 8'h37, 0);
        run_txn("wr30_poke", 0, 10, 1'b0, 8'h30, 8'h5A, 8'h5A, 5);
        run_txn("rd31_b2b", 0, 10, 1'b1, 8'h31, 8'h00, 8'hC3, 0);
        run_txn("wrF1_bad", 0, 10, 1'b0, 8'h40, 8'hF1, 8'hF0, 0);
        run_txn("wrF1_ok", 0, 10, 1'b0, 8'h40, 8'hF1, 8'hF1, 0);

        // T_PHASE=1 transactions
        run_txn("t1_wr21", 1, 1, 1'b0, 8'h21, 8'h45, 8'h45, 0);
        run_txn("t1_rd22", 1, 1, 1'b1, 8'h22, 8'h00, 8'h37, 0);
        run_txn("t1_wr_bad", 1, 1, 1'b0, 8'h07, 8'h81, 8'h80, 0);

        // Reset during A_STB of a write
        rw = 1'b0; addr = 8'h21; wdata = 8'h45; start0 = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            @(posedge CLK);
            #1;
            if (n == 1) start0 = 1'b0;
        end
        check("rst_pre_wr", WR0, 1'b0);
        RST = 1'b1; start0 = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_mid_bus", obs_bus(0), C_IDLE_BUS);
        check("rst_mid_rdata", rdata0, 8'h00);
        check("rst_mid_err", err0, 1'b0);
        RST = 1'b0; start0 = 1'b0;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        dn = 0; bz = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge CLK);
            #1;
            if (done0) dn++;
            if (busy0) bz++;
        end
        check("rst_no_done", dn, 0);
        check("rst_no_busy", bz, 0);

        // Reset wins over a simultaneous start in IDLE
        RST = 1'b1; start0 = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0; start0 = 1'b0;
        check("rst_prio_busy", busy0, 1'b0);
        @(posedge CLK);
        #1;
        check("rst_prio_idle", obs_bus(0), C_IDLE_BUS);

        run_txn("rd44_post_rst", 0, 10, 1'b1, 8'h44, 8'h00, 8'h9C, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rtc_bus_ctrl.md
RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 SHALL have parameter T_PHASE, default 10, meaning clock cycles per bus phase (legal 1..255).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start  input  1  transaction request, sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  1 = read, 0 = write; latched with start.
REQ-006 SHALL have port addr  input  8  RTC register address; latched with start.
REQ-007 SHALL have port wdata  input  8  write data; latched with start.
REQ-008 SHALL have port rdata  output  8  last read data; holds until the next read completes.
REQ-009 SHALL have port busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  write-verify mismatch flag, valid with done.
REQ-012 SHALL have ports CS, RD, WR, AD  output  1 each  active-low RTC strobes; AD low = address phase, high = data phase.
REQ-013 SHALL have ports ad_out  output  8 / ad_oe  output  1 / ad_in  input  8  split A_D_Bus; the tri-state buffer sits in top.

Function
REQ-014 SHALL implement states IDLE, A_SET, A_STB, A_HOLD, D_SET, D_STB, D_HOLD, FIN; every state except IDLE and FIN lasts exactly T_PHASE cycles, FIN lasts 1 cycle.
REQ-015 SHALL, in IDLE with start=1, latch rw/addr/wdata and enter A_SET on the next edge; start while busy SHALL be ignored, with no queuing.
REQ-016 SHALL drive CS=0 in all states A_SET..D_HOLD, and CS=1 in IDLE and FIN.
REQ-017 SHALL drive AD=0, ad_out=addr, ad_oe=1 in A_SET, A_STB and A_HOLD; WR=0 only in A_STB.
REQ-018 SHALL drive AD=1 in D_SET, D_STB and D_HOLD.
REQ-019 SHALL, on a write, drive ad_out=wdata, ad_oe=1 in D_SET..D_HOLD; WR=0 only in D_STB.
REQ-020 SHALL, on a read, hold ad_oe=0 in D_SET..D_HOLD and RD=0 only in D_STB; rdata SHALL capture ad_in on the last cycle of D_STB.
REQ-021 SHALL never assert RD and WR together, and never assert ad_oe while RD=0.
REQ-022 SHALL assert done=1 and busy=1 in FIN, then return to IDLE; total latency from accepted start to done SHALL be 6*T_PHASE+1 cycles.
REQ-023 SHALL use an 8-bit phase counter that reloads at every state entry; there is no wrap beyond T_PHASE-1.
REQ-024 SHALL accept a start asserted in the cycle after FIN, giving back-to-back transactions with one IDLE cycle between them.

Reset
REQ-025 SHALL, with RST=1 at a rising edge, force state IDLE, CS=RD=WR=AD=1, ad_oe=0, ad_out=0, rdata=0, busy=0, done=0, err=0, and clear latched operands.
REQ-026 SHALL abort a transaction mid-flight on reset, with no done pulse and strobes deasserted on the same edge; RST SHALL take priority over start.

Configuration
REQ-027 SHALL, when macro RTC_BUS_WRITE_VERIFY_EN is defined, follow each write (in place of its FIN) with an automatic read of the same address (A_SET..D_HOLD, rw=1), then FIN.
REQ-028 SHALL, in that verify FIN, set err=1 if the read-back value differs from wdata, else err=0; rdata SHALL show the read-back value; write latency SHALL become 12*T_PHASE+1.
REQ-029 SHALL, without RTC_BUS_WRITE_VERIFY_EN, tie err to 0 and keep write latency at 6*T_PHASE+1.

Verification
REQ-030 SHALL verify this write case: T_PHASE=10, start with rw=0, addr=8'h21, wdata=8'h45 -> ad_out=21 with AD=0 and WR low for 10 cycles, then ad_out=45 with AD=1 and WR low for 10 cycles, done at cycle 61, RD always high.
REQ-031 SHALL verify this read case: rw=1, addr=8'h22, bench drives ad_in=8'h37 during D_STB -> ad_oe=0 in the data phase, RD low for 10 cycles, rdata=37 with done at cycle 61.
REQ-032 SHALL verify that start pulsed again at cycle 5 of a transaction is ignored -> exactly one done; a start in the cycle after done is accepted.
REQ-033 SHALL verify reset mid-transaction: RST=1 during A_STB -> next edge CS=WR=1, ad_oe=0, busy=0, and no done.
REQ-034 SHALL verify the verify path with RTC_BUS_WRITE_VERIFY_EN defined: write 8'hF1 with ad_in returning 8'hF0 -> done at cycle 121 with err=1; with ad_in returning 8'hF1 -> err=0.
REQ-035 SHALL verify T_PHASE=1: a write completes in 7 cycles, and the strobe sequence matches REQ-017 and REQ-019.
